// File: rtl/cpu_program_loader.sv
// Loads a length-prefixed byte stream into CPU memory, then runs the CPU and counts cycles to HALT.
// Latency: memory write registered one cycle after each accepted byte; CPU released 2 cycles after the last byte.
// Backpressure: in_ready is high only in LEN/LOAD. Optional LOADER_ZERO_FILL_EN zero-fills unwritten addresses.
module cpu_program_loader #(
    parameter int WIDTH_REG = 8,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 32,
    parameter int CYC_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [WIDTH_REG-1:0] in_data,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WIDTH_REG-1:0] mem_wdata,
    output logic                 cpu_reset,
    input  logic                 cpu_halt,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CYC_W-1:0]     run_cycles
);

    // One extra bit so a full-depth load can count to DEPTH without wrapping.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_LOAD, S_FILL, S_RELEASE, S_RUN, S_HALTED
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       len_q, len_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [WIDTH_REG-1:0]   mem_wdata_q, mem_wdata_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [CYC_W-1:0]       run_cycles_q, run_cycles_d;

    logic                   xfer;
    logic                   len_bad;
    logic [CNT_W-1:0]       cnt_inc;

    assign xfer    = in_valid & in_ready;
    assign len_bad = (in_data == '0) || (in_data > WIDTH_REG'(DEPTH));
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            done_q       <= done_d;
            err_q        <= err_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_LEN;
            S_LEN:     if (xfer) state_d = len_bad ? S_IDLE : S_LOAD;
            S_LOAD: begin
                if (xfer && (cnt_inc == len_q)) begin
`ifdef LOADER_ZERO_FILL_EN
                    state_d = (len_q == DEPTH_C) ? S_RELEASE : S_FILL;
`else
                    state_d = S_RELEASE;
`endif
                end
            end
`ifdef LOADER_ZERO_FILL_EN
            S_FILL:    if (cnt_inc == DEPTH_C) state_d = S_RELEASE;
`endif
            S_RELEASE: state_d = S_RUN;
            // Abort takes priority over a coincident halt.
            S_RUN: begin
                if (start)         state_d = S_LEN;
                else if (cpu_halt) state_d = S_HALTED;
            end
            S_HALTED:  if (start) state_d = S_LEN;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        len_d        = len_q;
        cnt_d        = cnt_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = done_q;
        err_d        = err_q;
        run_cycles_d = run_cycles_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    run_cycles_d = '0;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    len_d = in_data[CNT_W-1:0];
                    cnt_d = '0;
                    if (len_bad) err_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q[ADDR_W-1:0];
                    mem_wdata_d = in_data;
                    cnt_d       = cnt_inc;
                end
            end
`ifdef LOADER_ZERO_FILL_EN
            S_FILL: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = cnt_q[ADDR_W-1:0];
                mem_wdata_d = '0;
                cnt_d       = cnt_inc;
            end
`endif
            S_RUN: begin
                if (start) begin
                    run_cycles_d = '0;
                end else if (cpu_halt) begin
                    done_d = 1'b1;
                end else if (run_cycles_q != '1) begin
                    run_cycles_d = run_cycles_q + CYC_W'(1);
                end
            end
            default: ;
        endcase
    end

    // The CPU stays released in HALTED; it re-enters reset only when a new load starts.
    always_comb begin
        in_ready  = (state_q == S_LEN) || (state_q == S_LOAD);
        cpu_reset = !((state_q == S_RUN) || (state_q == S_HALTED));
        busy      = !((state_q == S_IDLE) || (state_q == S_HALTED));
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign done       = done_q;
    assign err        = err_q;
    assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed bench for cpu_program_loader: load, gaps, bad length, full depth, abort, fill, async reset.
module tb_cpu_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        cpu_halt = 1'b0;
    logic        in_ready, mem_we, cpu_reset, busy, done, err;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [15:0] run_cycles;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int log_addr[$];
    int log_data[$];
    int log_cyc[$];
    logic [7:0] mem_model [32];

    cpu_program_loader dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .cpu_halt(cpu_halt), .busy(busy), .done(done), .err(err),
        .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    // Memory-side observer, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (mem_we === 1'b1) begin
            log_addr.push_back(int'(mem_addr));
            log_data.push_back(int'(mem_wdata));
            log_cyc.push_back(cyc);
            mem_model[mem_addr] = mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err, run_cycles} !==
            {1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            bad++;
            $display("FAIL reset_values got rdy=%b we=%b a=%0d d=%h crst=%b busy=%b done=%b err=%b rc=%0d",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err, run_cycles);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        pulse_start();
        total++;
        if ({busy, in_ready, cpu_reset} !== 3'b111) begin
            bad++; $display("FAIL basic_len_state got busy/rdy/crst=%b required 111", {busy, in_ready, cpu_reset});
        end
        clear_log();
        send_byte(8'd3); send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
        total++;
        if ({cpu_reset, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 5'd2, 8'hC3}) begin
            bad++; $display("FAIL basic_release got crst=%b we=%b a=%0d d=%h required 1 1 2 c3",
                            cpu_reset, mem_we, mem_addr, mem_wdata);
        end
        tick();
        total++;
        if ({cpu_reset, mem_we} !== 2'b00) begin
            bad++; $display("FAIL basic_cpu_release got crst=%b we=%b required 0 0", cpu_reset, mem_we);
        end
        total++;
        if (log_addr.size() != 3 || log_addr[0] != 0 || log_addr[1] != 1 || log_addr[2] != 2 ||
            log_data[0] != 'hA1 || log_data[1] != 'hB2 || log_data[2] != 'hC3 ||
            log_cyc[1] != log_cyc[0] + 1 || log_cyc[2] != log_cyc[1] + 1) begin
            bad++; $display("FAIL basic_writes got count=%0d required 3 consecutive writes A1,B2,C3 at 0..2",
                            log_addr.size());
        end
        repeat (10) tick();
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        total++;
        if ({done, busy, cpu_reset, run_cycles} !== {1'b1, 1'b0, 1'b0, 16'd10}) begin
            bad++; $display("FAIL basic_halt got done=%b busy=%b crst=%b rc=%0d required 1 0 0 10",
                            done, busy, cpu_reset, run_cycles);
        end
        tick();
        tick();
        total++;
        if ({done, run_cycles} !== {1'b1, 16'd10}) begin
            bad++; $display("FAIL halted_hold got done=%b rc=%0d required 1 10", done, run_cycles);
        end
    endtask

    task automatic test_gaps();
        pulse_start();
        total++;
        if ({cpu_reset, done, run_cycles, busy} !== {1'b1, 1'b0, 16'd0, 1'b1}) begin
            bad++; $display("FAIL restart_from_halted got crst=%b done=%b rc=%0d busy=%b required 1 0 0 1",
                            cpu_reset, done, run_cycles, busy);
        end
        clear_log();
        send_byte(8'd3);  tick();
        send_byte(8'hA1); tick();
        send_byte(8'hB2); tick();
        send_byte(8'hC3); tick();
        total++;
        if (log_addr.size() != 3 || log_addr[0] != 0 || log_addr[1] != 1 || log_addr[2] != 2 ||
            log_data[0] != 'hA1 || log_data[1] != 'hB2 || log_data[2] != 'hC3 ||
            log_cyc[1] != log_cyc[0] + 2 || log_cyc[2] != log_cyc[1] + 2) begin
            bad++; $display("FAIL gaps_writes got count=%0d required 3 writes A1,B2,C3 at 0..2 spaced 2",
                            log_addr.size());
        end
    endtask

    task automatic test_abort();
        repeat (3) tick();
        total++;
        if ({cpu_reset, run_cycles} !== {1'b0, 16'd3}) begin
            bad++; $display("FAIL run_count got crst=%b rc=%0d required 0 3", cpu_reset, run_cycles);
        end
        pulse_start();
        total++;
        if ({cpu_reset, run_cycles, in_ready, done, busy} !== {1'b1, 16'd0, 1'b1, 1'b0, 1'b1}) begin
            bad++; $display("FAIL abort got crst=%b rc=%0d rdy=%b done=%b busy=%b required 1 0 1 0 1",
                            cpu_reset, run_cycles, in_ready, done, busy);
        end
    endtask

    task automatic test_bad_len();
        clear_log();
        send_byte(8'd0);
        total++;
        if ({err, busy, in_ready, cpu_reset} !== 4'b1001) begin
            bad++; $display("FAIL len_zero got err/busy/rdy/crst=%b required 1001", {err, busy, in_ready, cpu_reset});
        end
        pulse_start();
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL start_clears_err got err=%b required 0", err);
        end
        send_byte(8'd33);
        tick();
        total++;
        if ({err, busy, log_addr.size() == 0} !== 3'b101) begin
            bad++; $display("FAIL len_33 got err=%b busy=%b writes=%0d required 1 0 0", err, busy, log_addr.size());
        end
    endtask

    task automatic test_full_depth();
        int errs = 0;
        pulse_start();
        clear_log();
        send_byte(8'd32);
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        tick();
        for (int i = 0; i < 32; i++) begin
            if (i >= log_addr.size() || log_addr[i] != i || log_data[i] != i) errs++;
        end
        total++;
        if (log_addr.size() != 32 || errs != 0) begin
            bad++; $display("FAIL full_depth_writes got count=%0d bad_entries=%0d required 32 0",
                            log_addr.size(), errs);
        end
        total++;
        if ({cpu_reset, mem_we, err} !== 3'b000) begin
            bad++; $display("FAIL full_depth_run got crst=%b we=%b err=%b required 0 0 0", cpu_reset, mem_we, err);
        end
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL full_depth_done got done=%b required 1", done);
        end
    endtask

    task automatic test_fill();
        int n = 0;
        int errs = 0;
`ifdef LOADER_ZERO_FILL_EN
        int exp_n = 31;
`else
        int exp_n = 1;
`endif
        pulse_start();
        clear_log();
        send_byte(8'd2); send_byte(8'h11); send_byte(8'h22);
        while (cpu_reset !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n != exp_n) begin
            bad++; $display("FAIL release_delay got %0d edges after last byte required %0d", n, exp_n);
        end
        tick();
`ifdef LOADER_ZERO_FILL_EN
        for (int i = 2; i < 32; i++) begin
            if (i >= log_addr.size() || log_addr[i] != i || log_data[i] != 0) errs++;
        end
        total++;
        if (log_addr.size() != 32 || errs != 0 || mem_model[5] !== 8'h00) begin
            bad++; $display("FAIL zero_fill got count=%0d bad_entries=%0d mem5=%h required 32 0 00",
                            log_addr.size(), errs, mem_model[5]);
        end
`else
        if (mem_model[0] !== 8'h11 || mem_model[1] !== 8'h22) errs++;
        total++;
        if (log_addr.size() != 2 || errs != 0 || mem_model[5] !== 8'h05) begin
            bad++; $display("FAIL no_fill got count=%0d bad_entries=%0d mem5=%h required 2 0 05",
                            log_addr.size(), errs, mem_model[5]);
        end
`endif
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
    endtask

    task automatic test_async_reset();
        pulse_start();
        send_byte(8'd5); send_byte(8'hAA); send_byte(8'hBB);
        #2 reset = 1'b0;
        #1;
        total++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err, run_cycles} !==
            {1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            bad++; $display("FAIL async_reset got rdy=%b we=%b a=%0d d=%h crst=%b busy=%b done=%b err=%b rc=%0d",
                            in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err, run_cycles);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_start_valid_idle();
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd5;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        total++;
        if ({busy, in_ready, err} !== 3'b110) begin
            bad++; $display("FAIL start_valid_idle got busy/rdy/err=%b required 110", {busy, in_ready, err});
        end
        clear_log();
        send_byte(8'd1); send_byte(8'h77);
        tick();
        total++;
        if (log_addr.size() != 1 || log_addr[0] != 0 || log_data[0] != 'h77) begin
            bad++; $display("FAIL idle_byte_ignored got count=%0d required one write 77 at 0", log_addr.size());
        end
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        total++;
        if ({done, busy} !== 2'b10) begin
            bad++; $display("FAIL single_byte_done got done=%b busy=%b required 1 0", done, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem_model[i] = 8'hxx;
        test_reset();
        test_basic();
        test_gaps();
        test_abort();
        test_bad_len();
        test_full_depth();
        test_fill();
        test_async_reset();
        test_start_valid_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_program_loader.md
Name: cpu_program_loader

Overview:
- Upstream feeder for the 8-bit RISC CPU.
- Accepts a length-prefixed byte stream over a valid/ready handshake and writes it into the CPU's 32-entry instruction/data memory.
- Holds the CPU in reset while loading, then releases it and counts execution cycles until the CPU raises HALT.
- Lets the bench or system reload and rerun programs without a global reset.

Parameters:
- WIDTH_REG, 8, data/byte width written to memory
- ADDR_W, 5, memory address width (matches CPU PC width)
- DEPTH, 32, memory entries; must equal 2**ADDR_W
- CYC_W, 16, width of execution cycle counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  one-cycle request to begin a load
- in_valid  in  1  upstream byte valid
- in_data  in  WIDTH_REG  upstream byte
- in_ready  out  1  loader accepts byte this cycle
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  ADDR_W  memory write address (registered)
- mem_wdata  out  WIDTH_REG  memory write data (registered)
- cpu_reset  out  1  active-high reset driven to the CPU
- cpu_halt  in  1  CPU HALT flag
- busy  out  1  high in any state except IDLE and HALTED
- done  out  1  program ran to HALT; sticky until next start
- err  out  1  bad length received; sticky until next start
- run_cycles  out  CYC_W  clock cycles spent in RUN

Behaviour:
- Reset (reset=0, async): state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, busy=0, done=0, err=0, run_cycles=0, internal len/cnt=0.
- Handshake: a byte transfers on a rising edge with in_valid=1 and in_ready=1.
- in_ready is combinational: 1 only in LEN and LOAD. in_valid outside those states is ignored and consumes no data.
- IDLE: cpu_reset=1. start=1 -> LEN; clears done, err and run_cycles.
- LEN: on transfer, len=in_data.
  - len==0 or len>DEPTH -> err=1, IDLE.
  - Otherwise cnt=0 -> LOAD.
- LOAD: each transfer registers mem_we=1, mem_addr=cnt, mem_wdata=in_data; write is visible one cycle after the transfer. cnt increments.
  - Transfer with cnt==len-1 -> RELEASE (or FILL, see Optional Feature).
  - mem_we=0 on any cycle without a transfer.
- RELEASE: one cycle. cpu_reset stays 1 so the last write lands; mem_we=0 -> RUN.
- RUN: cpu_reset=0. run_cycles increments every cycle and saturates at all-ones.
  - cpu_halt=1 -> HALTED, done=1, run_cycles frozen; the cycle on which halt is seen is not counted.
- HALTED: cpu_reset remains 0 (CPU self-halted); outputs hold. start -> LEN and cpu_reset=1 from the next edge.
- start in RUN aborts: -> LEN, cpu_reset=1 next edge, run_cycles cleared, done stays 0.
- start in LEN, LOAD, RELEASE or FILL is ignored.
- start and in_valid in the same IDLE cycle: only start acts. in_ready is 0 in IDLE, so no byte transfers.
- Async reset mid-load or mid-run: immediate return to reset values. The partial program in memory is not cleared.
- len==DEPTH: addresses 0..DEPTH-1 written, cnt must not overflow ADDR_W incorrectly; use ADDR_W+1-bit counter.

Optional Feature:
- Macro LOADER_ZERO_FILL_EN.
- Defined:
  - After the last LOAD transfer, state FILL writes 0 to addresses len..DEPTH-1, one per cycle (mem_we=1, in_ready=0), then -> RELEASE.
  - len==DEPTH skips FILL.
  - cpu_reset stays 1 throughout.
- Undefined: no FILL state; LOAD goes directly to RELEASE and untouched addresses keep prior contents.

Test Plan:
- Basic load/run: reset, start, stream 3,0xA1,0xB2,0xC3 with in_valid always 1 -> writes addr0=A1, addr1=B2, addr2=C3 on consecutive cycles. cpu_reset falls 2 cycles after last transfer. Halt asserted 10 cycles later -> done=1, run_cycles=10, busy=0.
- Backpressure/gaps: same stream with in_valid toggling 1/0 -> identical writes, mem_we only on cycles after transfers, no duplicate or skipped addresses.
- Bad length: start, length byte 0 -> err=1, state IDLE, no mem_we. Repeat with 33 -> err=1. Next start clears err.
- Full depth: length 32 then bytes 0..31 -> last write addr 31 data 31, no wrap to addr 0.
- Abort and async reset: start during RUN -> cpu_reset=1 next cycle, run_cycles=0, in_ready=1. Separately, reset=0 mid-LOAD -> all outputs at reset values immediately.
- LOADER_ZERO_FILL_EN: length 2 -> addresses 2..31 written with 0 over 30 cycles before cpu_reset falls. Without the macro, cpu_reset falls 2 cycles after the last byte.
